ram_access_ctrl: RTL and testbench

//  Initiator-side sequencer for the 8051 internal data RAM (responder `ram`). Accepts one

---
 rtl/ram_access_ctrl_pkg.sv | 40 ++++
 rtl/ram_access_ctrl_if.sv | 39 +++
 rtl/ram_access_ctrl_rmw_alu.sv | 28 ++
 rtl/ram_access_ctrl.sv | 129 ++++++++++++
 tb/tb_ram_access_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// Shared types for the internal-RAM access sequencer: op codes, FSM states, widths
// and small op-classification helpers.
package ram_access_ctrl_pkg;

  localparam int AW = 8;
  localparam int DW = 8;

  typedef enum logic [2:0] {
    OP_RD_BYTE = 3'd0,
    OP_WR_BYTE = 3'd1,
    OP_RD_BIT  = 3'd2,
    OP_WR_BIT  = 3'd3,
    OP_SETB    = 3'd4,
    OP_CLRB    = 3'd5,
    OP_CPLB    = 3'd6,
    OP_INC_DEC = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  function automatic logic is_bit_op(input op_t op);
    return (op == OP_RD_BIT) || (op == OP_WR_BIT) || (op == OP_SETB) ||
           (op == OP_CLRB) || (op == OP_CPLB);
  endfunction

  function automatic logic needs_read(input op_t op);
    return (op != OP_WR_BYTE) && (op != OP_WR_BIT);
  endfunction

  function automatic logic needs_write(input op_t op);
    return (op != OP_RD_BYTE) && (op != OP_RD_BIT);
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request/response channel from the execute stage plus the bus to the internal RAM.
// The sequencer uses the slave modport; the CPU/RAM environment uses master.
interface ram_access_ctrl_if;
  import ram_access_ctrl_pkg::*;

  logic          req_valid;
  logic          req_ready;
  op_t           req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          req_bit;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_bit;
  logic          resp_err;
  logic          ram_rd;
  logic          ram_wr;
  logic          ram_is_bit_addr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_in_data;
  logic          ram_in_bit_data;
  logic [DW-1:0] ram_out_data;
  logic          ram_out_bit_data;

  modport slave (
    input  req_valid, req_op, req_addr, req_data, req_bit,
    input  ram_out_data, ram_out_bit_data,
    output req_ready, resp_valid, resp_data, resp_bit, resp_err,
    output ram_rd, ram_wr, ram_is_bit_addr, ram_addr, ram_in_data, ram_in_bit_data
  );

  modport master (
    output req_valid, req_op, req_addr, req_data, req_bit,
    output ram_out_data, ram_out_bit_data,
    input  req_ready, resp_valid, resp_data, resp_bit, resp_err,
    input  ram_rd, ram_wr, ram_is_bit_addr, ram_addr, ram_in_data, ram_in_bit_data
  );

endinterface

// File: rtl/ram_access_ctrl_rmw_alu.sv
// Combinational modify step of read-modify-write ops: turns the captured byte/bit
// into the value to write back (or to return, for plain reads).
module rmw_alu
  import ram_access_ctrl_pkg::*;
(
  input  op_t           op,
  input  logic          dec,
  input  logic [DW-1:0] byte_in,
  input  logic          bit_in,
  output logic [DW-1:0] byte_out,
  output logic          bit_out
);

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  always_comb begin
    byte_out = byte_in;
    bit_out  = bit_in;
    case (op)
      OP_SETB:    bit_out  = 1'b1;
      OP_CLRB:    bit_out  = 1'b0;
      OP_CPLB:    bit_out  = ~bit_in;
      OP_INC_DEC: byte_out = dec ? (byte_in - ONE) : (byte_in + ONE);
      default:    ;
    endcase
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequencer between the execute stage and the internal data RAM: one op in flight,
// read/capture/write/respond stages, SFR-range addresses rejected without RAM access.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  ram_access_ctrl_if.slave bus
);

  state_t        state_reg, state_next;
  op_t           op_reg;
  logic [AW-1:0] addr_reg;
  logic          dec_reg;
  logic          err_reg;
  logic [DW-1:0] res_byte_reg;
  logic          res_bit_reg;
  logic          resp_valid_reg;
  logic [DW-1:0] resp_data_reg;
  logic          resp_bit_reg;
  logic          resp_err_reg;

  logic          xfer;
  logic [DW-1:0] alu_byte;
  logic          alu_bit;
  logic          rd_drive, wr_drive, is_bit_drive, in_bit_drive;
  logic [AW-1:0] addr_drive;
  logic [DW-1:0] in_data_drive;

  assign xfer = bus.req_valid && (state_reg == ST_IDLE);

  rmw_alu u_rmw_alu (
    .op       (op_reg),
    .dec      (dec_reg),
    .byte_in  (bus.ram_out_data),
    .bit_in   (bus.ram_out_bit_data),
    .byte_out (alu_byte),
    .bit_out  (alu_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      op_reg         <= OP_RD_BYTE;
      addr_reg       <= '0;
      dec_reg        <= 1'b0;
      err_reg        <= 1'b0;
      res_byte_reg   <= '0;
      res_bit_reg    <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      resp_bit_reg   <= 1'b0;
      resp_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      resp_valid_reg <= (state_reg == ST_RESP);
      // Write ops carry their data straight through res_*; read ops overwrite it in CAPTURE.
      if (xfer) begin
        op_reg       <= bus.req_op;
        addr_reg     <= bus.req_addr;
        dec_reg      <= bus.req_data[0];
        err_reg      <= bus.req_addr[AW-1];
        res_byte_reg <= bus.req_data;
        res_bit_reg  <= bus.req_bit;
      end
      if (state_reg == ST_CAPTURE) begin
        res_byte_reg <= alu_byte;
        res_bit_reg  <= alu_bit;
      end
      if (state_reg == ST_RESP) begin
        resp_err_reg  <= err_reg;
        resp_data_reg <= (err_reg || is_bit_op(op_reg)) ? '0 : res_byte_reg;
        resp_bit_reg  <= (!err_reg && is_bit_op(op_reg)) ? res_bit_reg : 1'b0;
      end
    end
  end

  // Outside READ/WRITE the RAM must see is_bit_addr=1, otherwise it performs a byte write.
  always_comb begin
    state_next    = state_reg;
    rd_drive      = 1'b0;
    wr_drive      = 1'b0;
    is_bit_drive  = 1'b1;
    addr_drive    = '0;
    in_data_drive = '0;
    in_bit_drive  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_addr[AW-1])          state_next = ST_RESP;
          else if (needs_read(bus.req_op)) state_next = ST_READ;
          else                             state_next = ST_WRITE;
        end
      end
      ST_READ: begin
        rd_drive     = 1'b1;
        is_bit_drive = is_bit_op(op_reg);
        addr_drive   = addr_reg;
        state_next   = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_next = needs_write(op_reg) ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        wr_drive     = 1'b1;
        is_bit_drive = is_bit_op(op_reg);
        addr_drive   = addr_reg;
        if (is_bit_op(op_reg)) in_bit_drive  = res_bit_reg;
        else                   in_data_drive = res_byte_reg;
        state_next   = ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.req_ready       = (state_reg == ST_IDLE);
  assign bus.resp_valid      = resp_valid_reg;
  assign bus.resp_data       = resp_data_reg;
  assign bus.resp_bit        = resp_bit_reg;
  assign bus.resp_err        = resp_err_reg;
  assign bus.ram_rd          = rd_drive;
  assign bus.ram_wr          = wr_drive;
  assign bus.ram_is_bit_addr = is_bit_drive;
  assign bus.ram_addr        = addr_drive;
  assign bus.ram_in_data     = in_data_drive;
  assign bus.ram_in_bit_data = in_bit_drive;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural internal-RAM model.
module tb_ram_access_ctrl;
  import ram_access_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  ram_access_ctrl_if bus ();

  ram_access_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: registered read; byte write whenever rd=0 and is_bit_addr=0; bit write on wr.
  logic [7:0] mem [0:255] = '{default: 8'h00};

  always @(posedge clk) begin
    if (bus.ram_rd) begin
      bus.ram_out_data     <= mem[bus.ram_addr];
      bus.ram_out_bit_data <= mem[{4'h2, bus.ram_addr[6:3]}][bus.ram_addr[2:0]];
    end else if (!bus.ram_is_bit_addr) begin
      mem[bus.ram_addr] <= bus.ram_in_data;
    end else if (bus.ram_wr) begin
      mem[{4'h2, bus.ram_addr[6:3]}][bus.ram_addr[2:0]] <= bus.ram_in_bit_data;
    end
  end

  always @(negedge clk) begin
    if (!bus.ram_rd && !bus.ram_wr) begin
      total++;
      if (bus.ram_is_bit_addr !== 1'b1) begin
        bad++;
        $display("FAIL idle_drive t=%0t is_bit_addr=%b want=1", $time, bus.ram_is_bit_addr);
      end
    end
  end

  int         lat;
  logic [7:0] r_data;
  logic       r_bit, r_err, r_ready_busy, r_access;

  task automatic run_op(input op_t op, input logic [7:0] addr, input logic [7:0] data,
                        input logic b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.req_bit   = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 99;
    r_access = 1'b0;
    r_ready_busy = bus.req_ready;
    r_data = 8'hxx;
    r_bit = 1'bx;
    r_err = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      if (bus.ram_rd || bus.ram_wr) r_access = 1'b1;
      @(posedge clk);
      #1;
      if (bus.resp_valid) begin
        lat = k;
        r_data = bus.resp_data;
        r_bit = bus.resp_bit;
        r_err = bus.resp_err;
        break;
      end
    end
    $display("op=%0d addr=%02h data=%02h bit=%b -> lat=%0d resp_data=%02h resp_bit=%b err=%b",
             op, addr, data, b, lat, r_data, r_bit, r_err);
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_op = OP_RD_BYTE;
    bus.req_addr = 8'h00;
    bus.req_data = 8'h00;
    bus.req_bit = 1'b0;
    #2;
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_bit, bus.resp_err} !== 12'h800) begin
      bad++;
      $display("FAIL reset_resp got ready=%b v=%b d=%02h b=%b e=%b want ready=1 rest 0",
               bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_bit, bus.resp_err);
    end
    total++;
    if ({bus.ram_rd, bus.ram_wr, bus.ram_is_bit_addr, bus.ram_addr, bus.ram_in_data,
         bus.ram_in_bit_data} !== 20'h20000) begin
      bad++;
      $display("FAIL reset_ram got rd=%b wr=%b isbit=%b addr=%02h in=%02h inbit=%b want 0 0 1 00 00 0",
               bus.ram_rd, bus.ram_wr, bus.ram_is_bit_addr, bus.ram_addr, bus.ram_in_data,
               bus.ram_in_bit_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    run_op(OP_WR_BYTE, 8'h30, 8'hA5, 1'b0);
    total++;
    if (lat !== 2 || r_data !== 8'hA5 || r_bit !== 1'b0 || r_err !== 1'b0) begin
      bad++;
      $display("FAIL wr_byte got lat=%0d d=%02h b=%b e=%b want 2 A5 0 0", lat, r_data, r_bit, r_err);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 8'hA5) begin
      bad++;
      $display("FAIL resp_hold got v=%b d=%02h want 0 A5", bus.resp_valid, bus.resp_data);
    end
    run_op(OP_RD_BYTE, 8'h30, 8'h00, 1'b0);
    total++;
    if (lat !== 3 || r_data !== 8'hA5 || r_bit !== 1'b0 || r_err !== 1'b0) begin
      bad++;
      $display("FAIL rd_byte got lat=%0d d=%02h b=%b e=%b want 3 A5 0 0", lat, r_data, r_bit, r_err);
    end
  endtask

  task automatic test_bit_ops();
    run_op(OP_SETB, 8'h0B, 8'h00, 1'b0);
    total++;
    if (lat !== 4 || r_bit !== 1'b1 || r_data !== 8'h00 || r_ready_busy !== 1'b0) begin
      bad++;
      $display("FAIL setb got lat=%0d b=%b d=%02h busy_ready=%b want 4 1 00 0",
               lat, r_bit, r_data, r_ready_busy);
    end
    run_op(OP_RD_BYTE, 8'h21, 8'h00, 1'b0);
    total++;
    if (lat !== 3 || r_data !== 8'h08) begin
      bad++;
      $display("FAIL setb_byte got lat=%0d d=%02h want 3 08", lat, r_data);
    end
    run_op(OP_CPLB, 8'h0B, 8'h00, 1'b0);
    total++;
    if (lat !== 4 || r_bit !== 1'b0) begin
      bad++;
      $display("FAIL cplb got lat=%0d b=%b want 4 0", lat, r_bit);
    end
    run_op(OP_WR_BIT, 8'h0B, 8'h00, 1'b1);
    total++;
    if (lat !== 2 || r_bit !== 1'b1 || r_data !== 8'h00) begin
      bad++;
      $display("FAIL wr_bit got lat=%0d b=%b d=%02h want 2 1 00", lat, r_bit, r_data);
    end
    run_op(OP_RD_BIT, 8'h0B, 8'h00, 1'b0);
    total++;
    if (lat !== 3 || r_bit !== 1'b1) begin
      bad++;
      $display("FAIL rd_bit got lat=%0d b=%b want 3 1", lat, r_bit);
    end
    run_op(OP_CLRB, 8'h0B, 8'h00, 1'b0);
    total++;
    if (lat !== 4 || r_bit !== 1'b0) begin
      bad++;
      $display("FAIL clrb got lat=%0d b=%b want 4 0", lat, r_bit);
    end
    run_op(OP_RD_BYTE, 8'h21, 8'h00, 1'b0);
    total++;
    if (r_data !== 8'h00) begin
      bad++;
      $display("FAIL clrb_byte got d=%02h want 00", r_data);
    end
  endtask

  task automatic test_inc_dec();
    run_op(OP_WR_BYTE, 8'h40, 8'hFF, 1'b0);
    run_op(OP_INC_DEC, 8'h40, 8'h00, 1'b0);
    total++;
    if (lat !== 4 || r_data !== 8'h00 || r_bit !== 1'b0 || r_ready_busy !== 1'b0) begin
      bad++;
      $display("FAIL inc_wrap got lat=%0d d=%02h b=%b busy_ready=%b want 4 00 0 0",
               lat, r_data, r_bit, r_ready_busy);
    end
    run_op(OP_RD_BYTE, 8'h40, 8'h00, 1'b0);
    total++;
    if (r_data !== 8'h00) begin
      bad++;
      $display("FAIL inc_mem got d=%02h want 00", r_data);
    end
    run_op(OP_WR_BYTE, 8'h41, 8'h00, 1'b0);
    run_op(OP_INC_DEC, 8'h41, 8'h01, 1'b0);
    total++;
    if (lat !== 4 || r_data !== 8'hFF) begin
      bad++;
      $display("FAIL dec_wrap got lat=%0d d=%02h want 4 FF", lat, r_data);
    end
    run_op(OP_RD_BYTE, 8'h41, 8'h00, 1'b0);
    total++;
    if (r_data !== 8'hFF) begin
      bad++;
      $display("FAIL dec_mem got d=%02h want FF", r_data);
    end
  endtask

  task automatic test_error();
    run_op(OP_RD_BYTE, 8'h85, 8'h00, 1'b0);
    total++;
    if (lat !== 1 || r_err !== 1'b1 || r_data !== 8'h00 || r_access !== 1'b0) begin
      bad++;
      $display("FAIL err_rd got lat=%0d e=%b d=%02h access=%b want 1 1 00 0",
               lat, r_err, r_data, r_access);
    end
    run_op(OP_SETB, 8'h90, 8'h00, 1'b0);
    total++;
    if (lat !== 1 || r_err !== 1'b1 || r_bit !== 1'b0 || r_access !== 1'b0) begin
      bad++;
      $display("FAIL err_setb got lat=%0d e=%b b=%b access=%b want 1 1 0 0",
               lat, r_err, r_bit, r_access);
    end
    run_op(OP_RD_BYTE, 8'h30, 8'h00, 1'b0);
    total++;
    if (r_err !== 1'b0 || r_data !== 8'hA5) begin
      bad++;
      $display("FAIL after_err got e=%b d=%02h want 0 A5", r_err, r_data);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    run_op(OP_WR_BYTE, 8'h50, 8'h10, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = OP_INC_DEC;
    bus.req_addr = 8'h50;
    bus.req_data = 8'h00;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 1'b1 || bus.ram_rd !== 1'b0 || bus.ram_wr !== 1'b0 ||
        bus.ram_is_bit_addr !== 1'b1 || bus.ram_addr !== 8'h00) begin
      bad++;
      $display("FAIL midrst_ram got ready=%b rd=%b wr=%b isbit=%b addr=%02h want 1 0 0 1 00",
               bus.req_ready, bus.ram_rd, bus.ram_wr, bus.ram_is_bit_addr, bus.ram_addr);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 8'h00 || bus.resp_err !== 1'b0) begin
      bad++;
      $display("FAIL midrst_resp got v=%b d=%02h e=%b want 0 00 0",
               bus.resp_valid, bus.resp_data, bus.resp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL midrst_noresp got pulses=%0d want 0", seen);
    end
    run_op(OP_INC_DEC, 8'h50, 8'h00, 1'b0);
    total++;
    if (lat !== 4 || r_data !== 8'h11) begin
      bad++;
      $display("FAIL midrst_next got lat=%0d d=%02h want 4 11", lat, r_data);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bit_ops();
    test_inc_dec();
    test_error();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
